// File: rtl/dc_axi_arbiter_if.sv
// One AXI-style link (AR/R/AW/W/B, single outstanding) between a cache master and memory.
// The read-return payload carries {tag, line}.
interface dc_axi_arbiter_if #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int TAG_W  = 64
);
  logic [ID_W-1:0]         arid;
  logic [ADDR_W-1:0]       araddr;
  logic                    arvalid;
  logic                    arready;
  logic [ID_W-1:0]         rid;
  logic [TAG_W+DATA_W-1:0] rdata;
  logic                    rvalid;
  logic                    rready;
  logic [ID_W-1:0]         awid;
  logic [ADDR_W-1:0]       awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [ID_W-1:0]         wid;
  logic [DATA_W-1:0]       wdata;
  logic                    wvalid;
  logic                    wready;
  logic [ID_W-1:0]         bid;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arvalid, input arready,
    input rid, rdata, rvalid, output rready,
    output awid, awaddr, awvalid, input awready,
    output wid, wdata, wvalid, input wready,
    input bid, bvalid, output bready
  );

  modport slave (
    input arid, araddr, arvalid, output arready,
    output rid, rdata, rvalid, input rready,
    input awid, awaddr, awvalid, output awready,
    input wid, wdata, wvalid, output wready,
    output bid, bvalid, input bready
  );
endinterface

// File: rtl/dc_axi_arbiter.sv
// Two-master to one-slave DRAM-cache arbiter: independent read and write paths, each
// single-outstanding with round-robin between M0/M1 on simultaneous requests.
module dc_axi_arbiter #(
  parameter int ID_W   = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int TAG_W  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  dc_axi_arbiter_if.slave  m0,
  dc_axi_arbiter_if.slave  m1,
  dc_axi_arbiter_if.master s,
  output logic             rd_grant,
  output logic             wr_grant,
  output logic             rd_busy,
  output logic             wr_busy
);
  localparam int RD_W = TAG_W + DATA_W;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

  rstate_t rstate_q, rstate_d;
  wstate_t wstate_q, wstate_d;
  logic    rown_q, rown_d, rd_ptr_q, rd_ptr_d;
  logic    wown_q, wown_d, wr_ptr_q, wr_ptr_d;

  // Master-side signals gathered into index-by-master arrays
  logic [1:0]             m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [1:0][ID_W-1:0]   m_arid, m_awid, m_wid;
  logic [1:0][ADDR_W-1:0] m_araddr, m_awaddr;
  logic [1:0][DATA_W-1:0] m_wdata;
  logic [1:0]             m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [1:0][ID_W-1:0]   m_rid, m_bid;
  logic [1:0][RD_W-1:0]   m_rdata;

  logic [ID_W-1:0]   s_arid, s_awid, s_wid;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

  assign m_arvalid = {m1.arvalid, m0.arvalid};
  assign m_arid    = {m1.arid,    m0.arid};
  assign m_araddr  = {m1.araddr,  m0.araddr};
  assign m_rready  = {m1.rready,  m0.rready};
  assign m_awvalid = {m1.awvalid, m0.awvalid};
  assign m_awid    = {m1.awid,    m0.awid};
  assign m_awaddr  = {m1.awaddr,  m0.awaddr};
  assign m_wvalid  = {m1.wvalid,  m0.wvalid};
  assign m_wid     = {m1.wid,     m0.wid};
  assign m_wdata   = {m1.wdata,   m0.wdata};
  assign m_bready  = {m1.bready,  m0.bready};

  assign m0.arready = m_arready[0];
  assign m1.arready = m_arready[1];
  assign m0.rvalid  = m_rvalid[0];
  assign m1.rvalid  = m_rvalid[1];
  assign m0.rid     = m_rid[0];
  assign m1.rid     = m_rid[1];
  assign m0.rdata   = m_rdata[0];
  assign m1.rdata   = m_rdata[1];
  assign m0.awready = m_awready[0];
  assign m1.awready = m_awready[1];
  assign m0.wready  = m_wready[0];
  assign m1.wready  = m_wready[1];
  assign m0.bvalid  = m_bvalid[0];
  assign m1.bvalid  = m_bvalid[1];
  assign m0.bid     = m_bid[0];
  assign m1.bid     = m_bid[1];

  assign s.arid    = s_arid;
  assign s.araddr  = s_araddr;
  assign s.arvalid = s_arvalid;
  assign s.rready  = s_rready;
  assign s.awid    = s_awid;
  assign s.awaddr  = s_awaddr;
  assign s.awvalid = s_awvalid;
  assign s.wid     = s_wid;
  assign s.wdata   = s_wdata;
  assign s.wvalid  = s_wvalid;
  assign s.bready  = s_bready;

  assign rd_grant = rown_q;
  assign wr_grant = wown_q;
  assign rd_busy  = (rstate_q != R_IDLE);
  assign wr_busy  = (wstate_q != W_IDLE);

  // Lone requester wins; on a tie the round-robin pointer decides
  function automatic logic pick(input logic [1:0] v, input logic ptr);
    return (&v) ? ptr : v[1];
  endfunction

  always_comb begin
    rstate_d  = rstate_q;
    rown_d    = rown_q;
    rd_ptr_d  = rd_ptr_q;
    s_arid    = '0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rid     = '0;
    m_rdata   = '0;
    unique case (rstate_q)
      R_IDLE: if (|m_arvalid) begin
        rown_d   = pick(m_arvalid, rd_ptr_q);
        rstate_d = R_ADDR;
      end
      R_ADDR: begin
        s_arid            = m_arid[rown_q];
        s_araddr          = m_araddr[rown_q];
        s_arvalid         = m_arvalid[rown_q];
        m_arready[rown_q] = s.arready;
        if (s_arvalid && s.arready) rstate_d = R_DATA;
      end
      R_DATA: begin
        m_rvalid[rown_q] = s.rvalid;
        m_rid[rown_q]    = s.rid;
        m_rdata[rown_q]  = s.rdata;
        s_rready         = m_rready[rown_q];
        if (s.rvalid && s_rready) begin
          rstate_d = R_IDLE;
          rd_ptr_d = ~rown_q;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d  = wstate_q;
    wown_d    = wown_q;
    wr_ptr_d  = wr_ptr_q;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wid     = '0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bid     = '0;
    unique case (wstate_q)
      W_IDLE: if (|m_awvalid) begin
        wown_d   = pick(m_awvalid, wr_ptr_q);
        wstate_d = W_ADDR;
      end
      W_ADDR: begin
        s_awid            = m_awid[wown_q];
        s_awaddr          = m_awaddr[wown_q];
        s_awvalid         = m_awvalid[wown_q];
        m_awready[wown_q] = s.awready;
        if (s_awvalid && s.awready) wstate_d = W_DATA;
      end
      W_DATA: begin
        s_wid            = m_wid[wown_q];
        s_wdata          = m_wdata[wown_q];
        s_wvalid         = m_wvalid[wown_q];
        m_wready[wown_q] = s.wready;
        if (s_wvalid && s.wready) wstate_d = W_RESP;
      end
      W_RESP: begin
        m_bvalid[wown_q] = s.bvalid;
        m_bid[wown_q]    = s.bid;
        s_bready         = m_bready[wown_q];
        if (s.bvalid && s_bready) begin
          wstate_d = W_IDLE;
          wr_ptr_d = ~wown_q;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reset abandons any in-flight transaction; a late slave response is simply not forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rown_q   <= 1'b0;
      rd_ptr_q <= 1'b0;
      wstate_q <= W_IDLE;
      wown_q   <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rown_q   <= rown_d;
      rd_ptr_q <= rd_ptr_d;
      wstate_q <= wstate_d;
      wown_q   <= wown_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
endmodule
